serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial N-bit unsigned subtractor controller: computes A - B one bit per cycle, LSB first.
- Reuses a single 1-bit full-subtractor cell with a registered borrow chain.
- Sits between a requester (start/done handshake) and the 1-bit subtract datapath. It trades latency for area versus a parallel ripple subtractor.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W (localparam), $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse; result valid.
- diff  output  WIDTH  A - B modulo 2^WIDTH.
- borrow  output  1  final borrow out; 1 iff A < B (unsigned).

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE; busy=0; done=0; diff=0; borrow=0.
  - Counter, operand shift registers and borrow flop all cleared.
  - An in-flight operation is discarded; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On edge with start=1: load a_sr<=a and b_sr<=b, clear borrow flop to 0, cnt<=0, go to RUN.
  - start=0: remain in IDLE.
- RUN, one bit per edge:
  - d = a_sr[0] ^ b_sr[0] ^ br.
  - br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - Shift a_sr and b_sr right by 1.
  - Shift d into the MSB of the result shift register (result ends LSB-aligned after WIDTH shifts).
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge: go to DONE. Exactly WIDTH RUN cycles occur.
- DONE (one cycle):
  - done=1, busy=1.
  - diff drives the result register; borrow drives the final br.
  - Next edge: go to IDLE unconditionally.
- Output hold: diff and borrow update only when entering DONE. They hold through IDLE until the next DONE, and are stable whenever done=1.
- Latency: start accepted at edge k; done is high during the cycle after edge k+WIDTH. Total is WIDTH+1 cycles from accept to done.
- Ignored inputs:
  - start while busy (RUN or DONE) is ignored; no queueing.
  - Changes on a/b after the accept edge have no effect on the result.
- Back-to-back operation: start held high continuously gives one operation every WIDTH+2 cycles. The IDLE cycle between operations is mandatory.
- Width rules:
  - diff is exactly WIDTH bits with wrap-around modulo 2^WIDTH.
  - borrow is the sole overflow indicator.
  - cnt never exceeds WIDTH-1.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package sub_pkg:
  - state enum type (IDLE/RUN/DONE, 2-bit encoding).
  - Default WIDTH constant shared with the parallel subtractor blocks.
- One sub-module, fs_bit: combinational 1-bit full subtractor with inputs a, b, bin and outputs d, bout. It is instantiated once. The controller holds all sequential state: FSM, counter, shift registers, borrow flop.

Test Plan (WIDTH=8):
- 200 - 55: rst_n released; start=1 for 1 cycle with a=8'd200, b=8'd55 -> busy for 9 cycles; done pulses exactly once, 9 cycles after the accept edge; diff=8'd145, borrow=0.
- 3 - 5: a=8'd3, b=8'd5 -> diff=8'hFE, borrow=1. Also 0 - 0 -> diff=0, borrow=0. Also 8'hFF - 8'h01 -> diff=8'hFE, borrow=0.
- start while busy: issue 10-5; pulse start with a=8'd99, b=8'd1 at cycle 3 of RUN; also change a/b mid-RUN -> single done, diff=8'd5, borrow=0. diff/borrow then hold through the following IDLE cycles.
- Reset mid-RUN: assert rst_n=0 at RUN cycle 4 (asynchronous, off-edge) -> outputs immediately 0, state IDLE, no done. A new start after release computes correctly, e.g. 8'd1 - 8'd2 -> 8'hFF, borrow=1.
- start held high continuously -> one done every 10 cycles; each result matches the operands present at its accept edge; a random sweep of ≥1000 pairs matches the reference model (a-b)&8'hFF and borrow=(a<b).

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and constants for the subtractor family (serial and parallel variants).
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fs_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one fs_bit cell, LSB-first, WIDTH run cycles
// followed by a single-cycle done pulse with the registered result.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic             d_bit;
    logic             b_out;

    fs_bit u_fs_bit (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (b_out)
    );

    // Controller: operands shift right into the cell while result bits enter at the
    // MSB, so after WIDTH shifts the result is LSB-aligned. diff/borrow only load
    // on the final RUN edge and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    br     <= b_out;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        cnt    <= '0;
                        done   <= 1'b1;
                        diff   <= {d_bit, res_sr[WIDTH-1:1]};
                        borrow <= b_out;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    // Runs one operation. mode 1 pulses start (99-1) mid-RUN and scrambles a/b.
    // Returns the result at done, the done latency in cycles after the accept
    // edge (-1 on timeout), busy cycles, done pulses and hold violations afterwards.
    task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input int mode,
                                 output logic [7:0] gotDiff, output logic gotBorrow,
                                 output int lat, output int busyCnt, output int doneCnt,
                                 output int holdErr);
        int  n;
        bit  seen;
        @(negedge clk);
        start = 1'b1;
        a     = opA;
        b     = opB;
        @(negedge clk);
        start     = 1'b0;
        lat       = -1;
        busyCnt   = 0;
        doneCnt   = 0;
        holdErr   = 0;
        seen      = 1'b0;
        gotDiff   = 'x;
        gotBorrow = 1'bx;
        n = 1;
        while (!seen && n <= 30) begin
            if (mode == 1 && n == 3) begin
                start = 1'b1;
                a     = 8'd99;
                b     = 8'd1;
            end else if (mode == 1 && n == 4) begin
                start = 1'b0;
                a     = 8'($urandom);
                b     = 8'($urandom);
            end
            if (busy) busyCnt++;
            if (done) begin
                seen      = 1'b1;
                lat       = n;
                doneCnt   = 1;
                gotDiff   = diff;
                gotBorrow = borrow;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
            if (diff !== gotDiff || borrow !== gotBorrow) holdErr++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h required 0", {busy, done, diff, borrow});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%0b done=%0b required 0/0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta [4] = '{8'd200, 8'd3, 8'd0, 8'hFF};
        logic [7:0] tb_[4] = '{8'd55,  8'd5, 8'd0, 8'h01};
        logic [7:0] expD;
        logic       expB;
        logic [7:0] gd;
        logic       gb;
        int lat, bc, dc, he;
        for (int i = 0; i < 4; i++) begin
            expD = 8'(ta[i] - tb_[i]);
            expB = (ta[i] < tb_[i]);
            applyStimulus(ta[i], tb_[i], 0, gd, gb, lat, bc, dc, he);
            checks++;
            if (gd !== expD || gb !== expB) begin
                failures++;
                $display("FAIL directed_%0d_%0d: got diff=%0h borrow=%0b required diff=%0h borrow=%0b",
                         ta[i], tb_[i], gd, gb, expD, expB);
            end
            checks++;
            if (lat !== WIDTH + 1 || bc !== WIDTH + 1 || dc !== 1) begin
                failures++;
                $display("FAIL directed_timing_%0d: got lat=%0d busy=%0d dones=%0d required %0d/%0d/1",
                         i, lat, bc, dc, WIDTH + 1, WIDTH + 1);
            end
            checks++;
            if (he !== 0) begin
                failures++;
                $display("FAIL directed_hold_%0d: got %0d hold errors required 0", i, he);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] gd;
        logic       gb;
        int lat, bc, dc, he;
        applyStimulus(8'd10, 8'd5, 1, gd, gb, lat, bc, dc, he);
        checks++;
        if (gd !== 8'd5 || gb !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_result: got diff=%0h borrow=%0b required 5/0", gd, gb);
        end
        checks++;
        if (dc !== 1 || lat !== WIDTH + 1) begin
            failures++;
            $display("FAIL busy_ignore_dones: got dones=%0d lat=%0d required 1/%0d", dc, lat, WIDTH + 1);
        end
        checks++;
        if (he !== 0) begin
            failures++;
            $display("FAIL busy_ignore_hold: got %0d hold errors required 0", he);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] gd;
        logic       gb;
        int lat, bc, dc, he, spurious;
        @(negedge clk);
        start = 1'b1;
        a     = 8'd77;
        b     = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, borrow} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_run: got %0h required 0", {busy, done, diff, borrow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("FAIL reset_discard: got %0d busy/done cycles required 0", spurious);
        end
        applyStimulus(8'd1, 8'd2, 0, gd, gb, lat, bc, dc, he);
        checks++;
        if (gd !== 8'hFF || gb !== 1'b1 || lat !== WIDTH + 1) begin
            failures++;
            $display("FAIL after_reset_op: got diff=%0h borrow=%0b lat=%0d required ff/1/%0d",
                     gd, gb, lat, WIDTH + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ha [400];
        logic [7:0] hb [400];
        logic [7:0] expD;
        logic       expB;
        int lastDone = -1;
        int nDone = 0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                nDone++;
                checks++;
                if (c < WIDTH + 1) begin
                    failures++;
                    $display("FAIL b2b_early_done: got done at cycle %0d required >= %0d", c, WIDTH + 1);
                end else begin
                    expD = 8'(ha[c-WIDTH-1] - hb[c-WIDTH-1]);
                    expB = (ha[c-WIDTH-1] < hb[c-WIDTH-1]);
                    if (diff !== expD || borrow !== expB) begin
                        failures++;
                        $display("FAIL b2b_result_c%0d: got diff=%0h borrow=%0b required diff=%0h borrow=%0b",
                                 c, diff, borrow, expD, expB);
                    end
                end
                if (lastDone >= 0) begin
                    checks++;
                    if (c - lastDone !== WIDTH + 2) begin
                        failures++;
                        $display("FAIL b2b_period: got %0d cycles required %0d", c - lastDone, WIDTH + 2);
                    end
                end
                lastDone = c;
            end
            start = 1'b1;
            a     = 8'($urandom);
            b     = 8'($urandom);
            ha[c] = a;
            hb[c] = b;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (nDone < 38) begin
            failures++;
            $display("FAIL b2b_count: got %0d dones required >= 38", nDone);
        end
        repeat (WIDTH + 4) @(negedge clk);
    endtask

    task automatic test_random_sweep();
        logic [7:0] ra, rb, gd;
        logic       gb;
        int lat, bc, dc, he;
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(ra, rb, 0, gd, gb, lat, bc, dc, he);
            checks++;
            if (gd !== 8'(ra - rb) || gb !== (ra < rb) || lat !== WIDTH + 1 || dc !== 1) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0h_%0h: got diff=%0h borrow=%0b lat=%0d dones=%0d required diff=%0h borrow=%0b",
                             ra, rb, gd, gb, lat, dc, 8'(ra - rb), (ra < rb));
            end
        end
    endtask

    initial begin
        $display("[TB] starting serial_sub_ctrl bench");
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
